// File: rtl/mem_stage_access.sv
// MEM stage: turns EX/MEM load/store requests into a req/ack memory access and registers the MEM/WB result.
// Optional MEM_ACK_TIMEOUT_EN adds a bounded-wait counter that retires a hung access and sets sticky mem_err.
module mem_stage_access #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] DM_data,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              stall,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state;
    logic   mem_op_c;
    logic   timeout_c;

    assign mem_op_c = ex_valid & (ex_mem_rd | ex_mem_wr);

`ifdef MEM_ACK_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // Fires on the TIMEOUT-th consecutive WAIT cycle without an ack; an ack in that cycle wins.
    assign timeout_c = (state == ST_WAIT) & ~dm_ack & (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_c = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // Gated by reset so the pipeline is released the instant reset is asserted.
    always_comb begin
        stall = 1'b0;
        if (reset) begin
            if (state == ST_IDLE) begin
                stall = mem_op_c;
            end else begin
                stall = ~dm_ack & ~timeout_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
`ifdef MEM_ACK_TIMEOUT_EN
            wait_cnt <= '0;
            mem_err  <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_op_c) begin
                        // rd=wr=1 resolves to a load.
                        dm_addr  <= ans_ex[ADDR_W-1:0];
                        dm_wdata <= DM_data;
                        dm_we    <= ~ex_mem_rd;
                        dm_req   <= 1'b1;
                        state    <= ST_WAIT;
`ifdef MEM_ACK_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else if (ex_valid) begin
                        wb_valid <= 1'b1;
                        wb_data  <= ans_ex;
                    end
                end
                ST_WAIT: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        state  <= ST_IDLE;
                        if (!dm_we) begin
                            wb_valid <= 1'b1;
                            wb_data  <= dm_rdata;
                        end
                    end else if (timeout_c) begin
                        dm_req <= 1'b0;
                        state  <= ST_IDLE;
`ifdef MEM_ACK_TIMEOUT_EN
                        mem_err <= 1'b1;
`endif
                    end else begin
`ifdef MEM_ACK_TIMEOUT_EN
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: per-cycle vector table plus hand-written reset and timeout sequences.
module tb_mem_stage_access;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid, ex_mem_rd, ex_mem_wr;
    logic [DATA_W-1:0] ans_ex, DM_data;
    logic              dm_req, dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;
    logic              stall, wb_valid, mem_err;
    logic [DATA_W-1:0] wb_data;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage_access #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ans_ex(ans_ex), .DM_data(DM_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ctl;      // {ex_valid, rd, wr}
        logic [7:0] ans;
        logic [7:0] dmd;
        logic       ack;
        logic [7:0] rdata;
        logic [2:0] e_flags;  // {stall before edge, dm_req after, dm_we after}
        logic [7:0] e_addr;
        logic [7:0] e_wdata;
        logic       e_wbv;
        logic [7:0] e_wbd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] c, input logic [7:0] a, input logic [7:0] d,
                                input logic k, input logic [7:0] r, input logic [2:0] f,
                                input logic [7:0] ea, input logic [7:0] ew, input logic v,
                                input logic [7:0] wd);
        vec_t t;
        t.ctl = c; t.ans = a; t.dmd = d; t.ack = k; t.rdata = r;
        t.e_flags = f; t.e_addr = ea; t.e_wdata = ew; t.e_wbv = v; t.e_wbd = wd;
        return t;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [7:0] a, input logic [7:0] d,
                         input logic k, input logic [7:0] r);
        ex_valid = c[2]; ex_mem_rd = c[1]; ex_mem_wr = c[0];
        ans_ex = a; DM_data = d; dm_ack = k; dm_rdata = r;
    endtask

    initial begin
        reset = 1'b0;
        drive(3'b000, 8'h00, 8'h00, 1'b0, 8'h00);

        // ALU, store with 2 ackless WAIT cycles, loads back-to-back, rd=wr=1, ack in IDLE.
        tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b0, 8'h00, 3'b000, 8'h00, 8'h00, 1'b0, 8'h00));
        tbl.push_back(mk(3'b100, 8'h3C, 8'h00, 1'b0, 8'h00, 3'b000, 8'h00, 8'h00, 1'b1, 8'h3C));
        tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b0, 8'h00, 3'b000, 8'h00, 8'h00, 1'b0, 8'h3C));
        tbl.push_back(mk(3'b101, 8'h10, 8'hA5, 1'b0, 8'h00, 3'b111, 8'h10, 8'hA5, 1'b0, 8'h3C));
        tbl.push_back(mk(3'b101, 8'h10, 8'hA5, 1'b0, 8'h00, 3'b111, 8'h10, 8'hA5, 1'b0, 8'h3C));
        tbl.push_back(mk(3'b101, 8'h10, 8'hA5, 1'b0, 8'h00, 3'b111, 8'h10, 8'hA5, 1'b0, 8'h3C));
        tbl.push_back(mk(3'b101, 8'h10, 8'hA5, 1'b1, 8'hEE, 3'b001, 8'h10, 8'hA5, 1'b0, 8'h3C));
        tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b0, 8'h00, 3'b001, 8'h10, 8'hA5, 1'b0, 8'h3C));
        tbl.push_back(mk(3'b110, 8'h20, 8'h00, 1'b0, 8'h00, 3'b110, 8'h20, 8'h00, 1'b0, 8'h3C));
        tbl.push_back(mk(3'b110, 8'h20, 8'h00, 1'b1, 8'h5A, 3'b000, 8'h20, 8'h00, 1'b1, 8'h5A));
        tbl.push_back(mk(3'b110, 8'h21, 8'h00, 1'b0, 8'h00, 3'b110, 8'h21, 8'h00, 1'b0, 8'h5A));
        tbl.push_back(mk(3'b110, 8'h21, 8'h00, 1'b1, 8'hC3, 3'b000, 8'h21, 8'h00, 1'b1, 8'hC3));
        tbl.push_back(mk(3'b111, 8'h30, 8'h77, 1'b0, 8'h00, 3'b110, 8'h30, 8'h77, 1'b0, 8'hC3));
        tbl.push_back(mk(3'b111, 8'h30, 8'h77, 1'b1, 8'h99, 3'b000, 8'h30, 8'h77, 1'b1, 8'h99));
        tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b1, 8'h12, 3'b000, 8'h30, 8'h77, 1'b0, 8'h99));
        tbl.push_back(mk(3'b100, 8'hFF, 8'h00, 1'b1, 8'h34, 3'b000, 8'h30, 8'h77, 1'b1, 8'hFF));
        tbl.push_back(mk(3'b101, 8'h40, 8'h11, 1'b0, 8'h00, 3'b111, 8'h40, 8'h11, 1'b0, 8'hFF));
        tbl.push_back(mk(3'b101, 8'h40, 8'h11, 1'b1, 8'h00, 3'b001, 8'h40, 8'h11, 1'b0, 8'hFF));
        tbl.push_back(mk(3'b100, 8'h07, 8'h00, 1'b0, 8'h00, 3'b001, 8'h40, 8'h11, 1'b1, 8'h07));

        repeat (2) @(posedge clk);
        #1;
        chk1("rst dm_req", dm_req, 1'b0);
        chk1("rst stall", stall, 1'b0);
        chk1("rst wb_valid", wb_valid, 1'b0);
        chk8("rst wb_data", wb_data, 8'h00);
        chk1("rst mem_err", mem_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].ctl, tbl[i].ans, tbl[i].dmd, tbl[i].ack, tbl[i].rdata);
            #1;
            chk1($sformatf("v%0d stall", i), stall, tbl[i].e_flags[2]);
            @(posedge clk);
            #1;
            chk1($sformatf("v%0d dm_req", i), dm_req, tbl[i].e_flags[1]);
            chk1($sformatf("v%0d dm_we", i), dm_we, tbl[i].e_flags[0]);
            chk8($sformatf("v%0d dm_addr", i), dm_addr, tbl[i].e_addr);
            chk8($sformatf("v%0d dm_wdata", i), dm_wdata, tbl[i].e_wdata);
            chk1($sformatf("v%0d wb_valid", i), wb_valid, tbl[i].e_wbv);
            chk8($sformatf("v%0d wb_data", i), wb_data, tbl[i].e_wbd);
            chk1($sformatf("v%0d mem_err", i), mem_err, 1'b0);
        end

        // Load that never sees an ack.
        @(negedge clk);
        drive(3'b110, 8'h55, 8'h00, 1'b0, 8'h00);
        #1;
        chk1("hang stall idle", stall, 1'b1);
        @(posedge clk);
        #1;
        chk1("hang dm_req", dm_req, 1'b1);
`ifdef MEM_ACK_TIMEOUT_EN
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            @(negedge clk);
            #1;
            chk1($sformatf("to w%0d stall", i), stall, 1'b1);
            @(posedge clk);
            #1;
            chk1($sformatf("to w%0d dm_req", i), dm_req, 1'b1);
        end
        @(negedge clk);
        #1;
        chk1("to last stall", stall, 1'b0);
        @(posedge clk);
        #1;
        chk1("to dm_req", dm_req, 1'b0);
        chk1("to mem_err", mem_err, 1'b1);
        chk1("to wb_valid", wb_valid, 1'b0);
        @(negedge clk);
        drive(3'b000, 8'h00, 8'h00, 1'b1, 8'h00);
        @(posedge clk);
        #1;
        chk1("to mem_err sticky", mem_err, 1'b1);
        chk1("to late ack wb_valid", wb_valid, 1'b0);
`else
        for (int i = 1; i < 21; i++) begin
            @(negedge clk);
            #1;
            chk1($sformatf("hang w%0d stall", i), stall, 1'b1);
            @(posedge clk);
            #1;
            chk1($sformatf("hang w%0d dm_req", i), dm_req, 1'b1);
        end
        @(negedge clk);
        drive(3'b110, 8'h55, 8'h00, 1'b1, 8'h66);
        #1;
        chk1("hang ack stall", stall, 1'b0);
        @(posedge clk);
        #1;
        chk1("hang wb_valid", wb_valid, 1'b1);
        chk8("hang wb_data", wb_data, 8'h66);
        chk1("hang mem_err", mem_err, 1'b0);
`endif

        // Reset asserted mid-access while the load is still presented.
        @(negedge clk);
        drive(3'b110, 8'h77, 8'h00, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        chk1("mr dm_req before", dm_req, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk1("mr dm_req", dm_req, 1'b0);
        chk1("mr stall", stall, 1'b0);
        chk1("mr wb_valid", wb_valid, 1'b0);
        chk8("mr wb_data", wb_data, 8'h00);
        chk1("mr mem_err", mem_err, 1'b0);
        chk8("mr dm_addr", dm_addr, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        drive(3'b100, 8'h3C, 8'h00, 1'b0, 8'h00);
        #1;
        chk1("mr alu stall", stall, 1'b0);
        @(posedge clk);
        #1;
        chk1("mr alu wb_valid", wb_valid, 1'b1);
        chk8("mr alu wb_data", wb_data, 8'h3C);
        chk1("mr alu dm_req", dm_req, 1'b0);

        // Reset coinciding with dm_ack in WAIT.
        @(negedge clk);
        drive(3'b110, 8'h42, 8'h00, 1'b0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        drive(3'b110, 8'h42, 8'h00, 1'b1, 8'hAA);
        reset = 1'b0;
        #1;
        chk1("ra dm_req", dm_req, 1'b0);
        chk1("ra stall", stall, 1'b0);
        @(posedge clk);
        #1;
        chk1("ra wb_valid", wb_valid, 1'b0);
        chk8("ra wb_data", wb_data, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        drive(3'b110, 8'h43, 8'h00, 1'b0, 8'h00);
        #1;
        chk1("ra ld stall", stall, 1'b1);
        @(posedge clk);
        #1;
        chk1("ra ld dm_req", dm_req, 1'b1);
        chk1("ra ld dm_we", dm_we, 1'b0);
        chk8("ra ld dm_addr", dm_addr, 8'h43);
        @(negedge clk);
        drive(3'b110, 8'h43, 8'h00, 1'b1, 8'h5A);
        #1;
        chk1("ra ack stall", stall, 1'b0);
        @(posedge clk);
        #1;
        chk1("ra ld wb_valid", wb_valid, 1'b1);
        chk8("ra ld wb_data", wb_data, 8'h5A);
        chk1("ra ld dm_req low", dm_req, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
